regs_wr_arbiter: RTL and testbench

- Shares the register file's single write port between two requesters.
  - Requester 0: core ALU/writeback.
  - Requester 1: I/O loader, which deposits switch/input values into registers.
- Round-robin arbitration with valid/ready handshakes.
- Presents one registered write per cycle to the register file's write, Waddr and Wdata inputs.
- Flags read-after-write hazards for the two register file read ports.

---
 rtl/regs_wr_arbiter_if.sv | 45 ++++
 rtl/regs_wr_arbiter.sv | 112 +++++++++++
 tb/tb_regs_wr_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/regs_wr_arbiter_if.sv
// Write-port bundle between the two requesters, the arbiter and the register file.
// Optional statistics ports are present when REGS_WR_ARB_STATS_EN is defined.
interface regs_wr_arbiter_if #(
  parameter int unsigned n = 8
);
  localparam int unsigned AW = 3;

  logic          v0;
  logic [AW-1:0] a0;
  logic [n-1:0]  d0;
  logic          rdy0;
  logic          v1;
  logic [AW-1:0] a1;
  logic [n-1:0]  d1;
  logic          rdy1;
  logic          write;
  logic [AW-1:0] Waddr;
  logic [n-1:0]  Wdata;
  logic [AW-1:0] Raddr1;
  logic [AW-1:0] Raddr2;
  logic          hazard1;
  logic          hazard2;
`ifdef REGS_WR_ARB_STATS_EN
  logic [15:0]   gcnt0;
  logic [15:0]   gcnt1;

  modport slave (
    input  v0, a0, d0, v1, a1, d1, Raddr1, Raddr2,
    output rdy0, rdy1, write, Waddr, Wdata, hazard1, hazard2, gcnt0, gcnt1
  );
  modport master (
    output v0, a0, d0, v1, a1, d1, Raddr1, Raddr2,
    input  rdy0, rdy1, write, Waddr, Wdata, hazard1, hazard2, gcnt0, gcnt1
  );
`else
  modport slave (
    input  v0, a0, d0, v1, a1, d1, Raddr1, Raddr2,
    output rdy0, rdy1, write, Waddr, Wdata, hazard1, hazard2
  );
  modport master (
    output v0, a0, d0, v1, a1, d1, Raddr1, Raddr2,
    input  rdy0, rdy1, write, Waddr, Wdata, hazard1, hazard2
  );
`endif
endinterface

// File: rtl/regs_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port between the core
// (requester 0) and the I/O loader (requester 1), with a one-cycle registered
// write stage and read-after-write hazard flags.
// Optional grant counters: define REGS_WR_ARB_STATS_EN.
module regs_wr_arbiter #(
  parameter int unsigned n       = 8,
  parameter bit          RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  regs_wr_arbiter_if.slave  bus
);
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 16;

  logic          prio_q, prio_d;
  logic          gnt0_c, gnt1_c;
  logic          write_q, write_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [n-1:0]  wdata_q, wdata_d;

  // Priority pointer register: 0 favours the core, 1 favours the loader.
  always_ff @(posedge clk) begin
    if (reset) prio_q <= RR_INIT;
    else       prio_q <= prio_d;
  end

  // Pointer only moves after a contended grant.
  always_comb begin
    prio_d = prio_q;
    if (bus.v0 && bus.v1) prio_d = ~prio_q;
  end

  // Grant decode; nothing is accepted while reset is asserted.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!reset) begin
      if (bus.v0 && bus.v1) begin
        gnt0_c = ~prio_q;
        gnt1_c = prio_q;
      end else begin
        gnt0_c = bus.v0;
        gnt1_c = bus.v1;
      end
    end
  end

  // Next write: register 0 is hardwired, so its grant consumes the slot without writing.
  always_comb begin
    write_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (gnt0_c) begin
      write_d = (bus.a0 != '0);
      waddr_d = bus.a0;
      wdata_d = bus.d0;
    end else if (gnt1_c) begin
      write_d = (bus.a1 != '0);
      waddr_d = bus.a1;
      wdata_d = bus.d1;
    end
  end

  // Registered write stage; reset drops any write already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.rdy0    = gnt0_c;
  assign bus.rdy1    = gnt1_c;
  assign bus.write   = write_q;
  assign bus.Waddr   = waddr_q;
  assign bus.Wdata   = wdata_q;
  assign bus.hazard1 = write_q && (waddr_q == bus.Raddr1) && (waddr_q != '0);
  assign bus.hazard2 = write_q && (waddr_q == bus.Raddr2) && (waddr_q != '0);

`ifdef REGS_WR_ARB_STATS_EN
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;

  // Saturating per-requester accepted-transfer counts.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt0_c && (cnt0_q != {CW{1'b1}})) cnt0_d = cnt0_q + CW'(1);
    if (gnt1_c && (cnt1_q != {CW{1'b1}})) cnt1_d = cnt1_q + CW'(1);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.gcnt0 = cnt0_q;
  assign bus.gcnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Scoreboard bench for regs_wr_arbiter: directed scenarios then random traffic,
// compared against a transaction-level model of the arbitration rules.
module tb_regs_wr_arbiter;
  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  regs_wr_arbiter_if #(.n(8)) ifc ();

  regs_wr_arbiter #(.n(8), .RR_INIT(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    int         cyc;
    bit         wr;
    bit         known;
    logic [2:0] addr;
    logic [7:0] data;
    int         c0;
    int         c1;
  } exp_t;

  exp_t q[$];

  // Reference model state
  int         owner;
  logic [2:0] m_addr;
  logic [7:0] m_data;
  bit         m_known;
  int         m_c0, m_c1;
  logic [2:0] r1_drv, r2_drv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // One clock of stimulus; returns the grants the model predicts.
  task automatic step(input bit rst, input bit v0, input logic [2:0] a0, input logic [7:0] d0,
                      input bit v1, input logic [2:0] a1, input logic [7:0] d1,
                      input logic [2:0] r1, input logic [2:0] r2, output bit g0, output bit g1);
    exp_t e;
    bit   wr;
    @(posedge clk);
    #1;
    reset      = rst;
    ifc.v0     = v0;
    ifc.a0     = a0;
    ifc.d0     = d0;
    ifc.v1     = v1;
    ifc.a1     = a1;
    ifc.d1     = d1;
    ifc.Raddr1 = r1;
    ifc.Raddr2 = r2;
    r1_drv     = r1;
    r2_drv     = r2;
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (v0 && v1) begin
        g0    = (owner == 0);
        g1    = (owner == 1);
        owner = 1 - owner;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    chk("rdy0", 32'(ifc.rdy0), 32'(g0));
    chk("rdy1", 32'(ifc.rdy1), 32'(g1));
    wr = 1'b0;
    if (rst) begin
      owner   = 0;
      m_addr  = 3'd0;
      m_data  = 8'd0;
      m_known = 1'b1;
      m_c0    = 0;
      m_c1    = 0;
    end else if (g0 || g1) begin
      m_addr  = g0 ? a0 : a1;
      m_data  = g0 ? d0 : d1;
      wr      = (m_addr != 3'd0);
      m_known = wr;
      if (g0 && m_c0 < 65535) m_c0++;
      if (g1 && m_c1 < 65535) m_c1++;
    end
    e.cyc   = cyc + 1;
    e.wr    = wr;
    e.known = m_known;
    e.addr  = m_addr;
    e.data  = m_data;
    e.c0    = m_c0;
    e.c1    = m_c1;
    q.push_back(e);
  endtask

  // Monitor: compares the registered write stage against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("missed_entry", 32'(e.cyc), 32'(cyc));
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("write", 32'(ifc.write), 32'(e.wr));
      if (e.known) begin
        chk("Waddr", 32'(ifc.Waddr), 32'(e.addr));
        chk("Wdata", 32'(ifc.Wdata), 32'(e.data));
      end
      chk("hazard1", 32'(ifc.hazard1), 32'(e.wr && e.addr == r1_drv && e.addr != 3'd0));
      chk("hazard2", 32'(ifc.hazard2), 32'(e.wr && e.addr == r2_drv && e.addr != 3'd0));
`ifdef REGS_WR_ARB_STATS_EN
      chk("gcnt0", 32'(ifc.gcnt0), 32'(e.c0));
      chk("gcnt1", 32'(ifc.gcnt1), 32'(e.c1));
`endif
    end
  end

  task automatic idle(input int k);
    bit g0, g1;
    for (int i = 0; i < k; i++)
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, g0, g1);
  endtask

  initial begin
    bit         g0, g1;
    bit         p0, p1, rst;
    logic [2:0] pa0, pa1, rr1, rr2;
    logic [7:0] pd0, pd1;
    cyc = 0; checks = 0; errors = 0;
    owner = 0; m_addr = 3'd0; m_data = 8'd0; m_known = 1'b0; m_c0 = 0; m_c1 = 0;
    r1_drv = 3'd0; r2_drv = 3'd0;
    reset = 1'b1;
    ifc.v0 = 1'b0; ifc.a0 = 3'd0; ifc.d0 = 8'd0;
    ifc.v1 = 1'b0; ifc.a1 = 3'd0; ifc.d1 = 8'd0;
    ifc.Raddr1 = 3'd0; ifc.Raddr2 = 3'd0;

    // Reset held with both requesters valid
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 3'd0, 3'd0, g0, g1);
    // Continuous contention: alternating grants, one write per cycle
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 3'd1, 3'd2, g0, g1);
    idle(1);
    // Single write from requester 0
    step(1'b0, 1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, g0, g1);
    idle(2);
    // Register-0 request from requester 1, then a normal request to register 5
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, g0, g1);
    step(1'b0, 1'b1, 3'd5, 8'h77, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, g0, g1);
    idle(1);
    // Hazards on register 4, then a register-0 slot
    step(1'b0, 1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, g0, g1);
    step(1'b0, 1'b1, 3'd0, 8'h99, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4, g0, g1);
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, g0, g1);
    step(1'b0, 1'b1, 3'd4, 8'h45, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, g0, g1);
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd4, 3'd0, g0, g1);
    // Accepted write followed immediately by reset, requester staying valid
    step(1'b0, 1'b1, 3'd6, 8'h66, 1'b1, 3'd7, 8'h70, 3'd6, 3'd7, g0, g1);
    step(1'b1, 1'b1, 3'd6, 8'h67, 1'b1, 3'd7, 8'h70, 3'd6, 3'd7, g0, g1);
    step(1'b0, 1'b1, 3'd6, 8'h67, 1'b1, 3'd7, 8'h70, 3'd6, 3'd7, g0, g1);
    idle(2);

    // Random traffic obeying hold-until-accepted, with occasional resets
    p0 = 1'b0; p1 = 1'b0;
    pa0 = 3'd0; pa1 = 3'd0; pd0 = 8'd0; pd1 = 8'd0;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1; pa0 = 3'($urandom_range(0, 7)); pd0 = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; pa1 = 3'($urandom_range(0, 7)); pd1 = 8'($urandom);
      end
      rr1 = 3'($urandom_range(0, 7));
      rr2 = 3'($urandom_range(0, 7));
      step(rst, p0, pa0, pd0, p1, pa1, pd1, rr1, rr2, g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
    idle(3);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
